counter_timer_high: RTL

Upper 32-bit word of the Caravel chained 64-bit counter/timer. It also works as a standalone 32-bit counter/timer. In chained mode it steps once per low-word rollover strobe and reports its own terminal condition back to the low word, so the pair stops, reloads and interrupts as one 64-bit unit. It sits behind its own Wishbone register wrapper and is wired point-to-point to the low-word counter.

---
 rtl/counter_timer_pkg.sv | 36 +++
 rtl/counter_timer_capture.sv | 34 +++
 rtl/counter_timer_high.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/counter_timer_pkg.sv
// Shared definitions for the chained counter/timer words: config bit layout
// and the byte-lane merge used by the value registers.
package counter_timer_pkg;

    localparam int CT_CFG_W       = 5;
    localparam int CT_CFG_ENABLE  = 0;
    localparam int CT_CFG_ONESHOT = 1;
    localparam int CT_CFG_UPDOWN  = 2;
    localparam int CT_CFG_CHAIN   = 3;
    localparam int CT_CFG_IRQENA  = 4;

    function automatic logic [31:0] ct_byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Unchained terminal test: up counts end at value_reset, down counts at 0.
    function automatic logic ct_terminal(
        input logic [31:0] v,
        input logic [31:0] rv,
        input logic        up
    );
        return up ? (v == rv) : (v == 32'd0);
    endfunction

endpackage

// File: rtl/counter_timer_capture.sv
// Capture unit: synchronises an external capture strobe and latches the
// counter value on its rising edge. Read-only from the bus side.
module counter_timer_capture (
    input  logic        clkin,
    input  logic        resetn,
    input  logic        capture_in,
    input  logic [31:0] value,
    output logic [31:0] cap_value
);

    logic sync_1;
    logic sync_2;
    logic sync_3;
    logic rise;

    assign rise = sync_2 & ~sync_3;

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_3    <= 1'b0;
            cap_value <= 32'd0;
        end else begin
            sync_1 <= capture_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            if (rise) begin
                cap_value <= value;
            end
        end
    end

endmodule

// File: rtl/counter_timer_high.sv
// Upper word of the chained 64-bit counter/timer; also usable standalone.
// Optional capture unit enabled by COUNTER_TIMER_HIGH_CAPTURE_EN.
module counter_timer_high
    import counter_timer_pkg::*;
(
    input  logic        clkin,
    input  logic        resetn,
    input  logic        reg_cfg_we,
    input  logic [31:0] reg_cfg_di,
    output logic [31:0] reg_cfg_do,
    input  logic [3:0]  reg_val_we,
    input  logic [31:0] reg_val_di,
    output logic [31:0] reg_val_do,
    input  logic [3:0]  reg_dat_we,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    input  logic        enable_in,
    input  logic        stop_in,
    input  logic        strobe,
    input  logic        is_offset,
    output logic        enable_out,
    output logic        stop_out,
    output logic        irq_out
`ifdef COUNTER_TIMER_HIGH_CAPTURE_EN
    ,
    input  logic        capture_in,
    output logic [31:0] reg_cap_do
`endif
);

    logic [CT_CFG_W-1:0] cfg;
    logic [31:0]         value_reset;
    logic [31:0]         value_cur;
    logic [31:0]         next_cur;
    logic                lastenable;
    logic                stop_reg;
    logic                stop_last;
    logic                irq_reg;
    logic                enable;
    logic                oneshot;
    logic                updown;
    logic                chain;
    logic                irq_ena;
    logic                loc_enable;
    logic                stop_chain;
    logic [31:0]         reload_val;
    logic                unused_cfg_bits;

    assign enable  = cfg[CT_CFG_ENABLE];
    assign oneshot = cfg[CT_CFG_ONESHOT];
    assign updown  = cfg[CT_CFG_UPDOWN];
    assign chain   = cfg[CT_CFG_CHAIN];
    assign irq_ena = cfg[CT_CFG_IRQENA];

    assign loc_enable = chain ? (enable & enable_in) : enable;
    assign reload_val = updown ? 32'd0 : value_reset;

    // With is_offset the low word's final pass ends one high-word step early.
    assign stop_chain = updown ?
        (is_offset ? ((value_cur + 32'd1) == value_reset) : (value_cur == value_reset)) :
        (value_cur == 32'd0);

    assign unused_cfg_bits = ^reg_cfg_di[31:CT_CFG_W];

    always_comb begin
        next_cur = value_cur;
        if (reg_dat_we != 4'b0000) begin
            next_cur = ct_byte_merge(value_cur, reg_dat_di, reg_dat_we);
        end else if (loc_enable) begin
            if (!lastenable) begin
                next_cur = reload_val;
            end else if (chain) begin
                // At the terminal the word waits for the low word's stop flag.
                if (stop_chain) begin
                    if (stop_in && !oneshot) begin
                        next_cur = reload_val;
                    end
                end else if (strobe) begin
                    next_cur = updown ? (value_cur + 32'd1) : (value_cur - 32'd1);
                end
            end else begin
                if (ct_terminal(value_cur, value_reset, updown)) begin
                    if (!oneshot) begin
                        next_cur = reload_val;
                    end
                end else begin
                    next_cur = updown ? (value_cur + 32'd1) : (value_cur - 32'd1);
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            cfg         <= '0;
            value_reset <= 32'd0;
            value_cur   <= 32'd0;
            lastenable  <= 1'b0;
            stop_reg    <= 1'b0;
            stop_last   <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            if (reg_cfg_we) begin
                cfg <= reg_cfg_di[CT_CFG_W-1:0];
            end
            value_reset <= ct_byte_merge(value_reset, reg_val_di, reg_val_we);
            value_cur   <= next_cur;
            lastenable  <= loc_enable;

            // Registered terminal flag tracks the value being loaded this edge.
            if (!chain && loc_enable) begin
                stop_reg <= ct_terminal(next_cur, value_reset, updown);
            end else begin
                stop_reg <= 1'b0;
            end
            stop_last <= stop_reg;

            if (!loc_enable) begin
                irq_reg <= 1'b0;
            end else if (chain) begin
                irq_reg <= irq_ena & stop_chain & stop_in;
            end else begin
                irq_reg <= irq_ena & stop_reg & ~stop_last;
            end
        end
    end

    assign reg_cfg_do = {{(32-CT_CFG_W){1'b0}}, cfg};
    assign reg_val_do = value_reset;
    assign reg_dat_do = value_cur;
    assign enable_out = enable;
    assign stop_out   = chain ? stop_chain : stop_reg;
    assign irq_out    = irq_reg;

`ifdef COUNTER_TIMER_HIGH_CAPTURE_EN
    counter_timer_capture u_capture (
        .clkin      (clkin),
        .resetn     (resetn),
        .capture_in (capture_in),
        .value      (value_cur),
        .cap_value  (reg_cap_do)
    );
`endif

endmodule
